vfu_slot_responder: RTL and testbench



---
 rtl/vfu_slot_responder.sv | 196 +++++++++++++++++++
 tb/tb_vfu_slot_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vfu_slot_responder.sv
// vfu_slot_responder: VFU-side endpoint of the slot request interface.
// It accepts requests, runs a simple integer op through a fixed-latency
// pipeline, and returns in-order responses through a credit-protected queue.
// Optional feature macro: VFU_SLOT_RESPONDER_FLOW_EN. When it is defined, the
// last pipeline stage may drive io_out directly if the response queue is empty.
module vfu_slot_responder #(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_in_ready,
    input  logic        io_in_valid,
    input  logic [32:0] io_in_bits_src_0,
    input  logic [32:0] io_in_bits_src_1,
    input  logic [3:0]  io_in_bits_opcode,
    input  logic [3:0]  io_in_bits_mask,
    input  logic [1:0]  io_in_bits_executeIndex,
    input  logic [5:0]  io_in_bits_groupIndex,
    input  logic [1:0]  io_in_bits_tag,
    input  logic        io_out_ready,
    output logic        io_out_valid,
    output logic [31:0] io_out_bits_data,
    output logic [1:0]  io_out_bits_executeIndex,
    output logic [5:0]  io_out_bits_groupIndex,
    output logic [1:0]  io_out_bits_tag
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(QUEUE_DEPTH + 1);

    // Outstanding credits: pipeline entries plus queued responses
    logic [OCC_W-1:0] occ;
    logic             accept;
    logic             pop;

    // Execute-stage result
    logic [31:0]      exec_data;

    // Pipeline stages
    logic [LATENCY-1:0] st_valid;
    logic [31:0]        st_data [LATENCY];
    logic [1:0]         st_eidx [LATENCY];
    logic [5:0]         st_gidx [LATENCY];
    logic [1:0]         st_tag  [LATENCY];
    logic               last_valid;

    // Response queue
    logic [31:0]      q_data [QUEUE_DEPTH];
    logic [1:0]       q_eidx [QUEUE_DEPTH];
    logic [5:0]       q_gidx [QUEUE_DEPTH];
    logic [1:0]       q_tag  [QUEUE_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] count;
    logic             queue_empty;
    logic             enq;
    logic             deq;
    logic             bypass;

    // Bit 32 of each operand is carried on the interface but has no meaning here
    logic             unused_src_msb;
    assign unused_src_msb = io_in_bits_src_0[32] ^ io_in_bits_src_1[32];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign io_in_ready = !reset && (occ < OCC_W'(QUEUE_DEPTH));
    assign accept      = io_in_valid && io_in_ready;
    assign pop         = io_out_valid && io_out_ready;
    assign last_valid  = st_valid[LATENCY-1];
    assign queue_empty = (count == '0);
    assign deq         = !queue_empty && io_out_ready;

`ifdef VFU_SLOT_RESPONDER_FLOW_EN
    assign io_out_valid = !queue_empty || last_valid;
    assign bypass       = queue_empty && last_valid && io_out_ready;
`else
    assign io_out_valid = !queue_empty;
    assign bypass       = 1'b0;
`endif

    // A bypassed entry is consumed straight from the last stage and never queued
    assign enq = last_valid && !bypass;

    // Execute the op on the low 32 bits and clear disabled result bytes
    always_comb begin
        exec_data = '0;
        case (io_in_bits_opcode)
            4'd0:    exec_data = io_in_bits_src_0[31:0] & io_in_bits_src_1[31:0];
            4'd1:    exec_data = io_in_bits_src_0[31:0] | io_in_bits_src_1[31:0];
            4'd2:    exec_data = io_in_bits_src_0[31:0] ^ io_in_bits_src_1[31:0];
            4'd3:    exec_data = io_in_bits_src_0[31:0] + io_in_bits_src_1[31:0];
            default: exec_data = io_in_bits_src_0[31:0];
        endcase
        for (int unsigned i = 0; i < 4; i++) begin
            if (!io_in_bits_mask[i]) begin
                exec_data[i*8 +: 8] = '0;
            end
        end
    end

    // Credit counter: accept and pop in the same cycle cancel out
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Pipeline valid bits shift every cycle; the pipeline never stalls
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_valid <= '0;
        end else begin
            st_valid[0] <= accept;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
            end
        end
    end

    // Pipeline payload follows the valid bits and needs no reset
    always_ff @(posedge clock) begin
        st_data[0] <= exec_data;
        st_eidx[0] <= io_in_bits_executeIndex;
        st_gidx[0] <= io_in_bits_groupIndex;
        st_tag[0]  <= io_in_bits_tag;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            st_data[i] <= st_data[i-1];
            st_eidx[i] <= st_eidx[i-1];
            st_gidx[i] <= st_gidx[i-1];
            st_tag[i]  <= st_tag[i-1];
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= ptr_inc(tail);
            end
            if (deq) begin
                head <= ptr_inc(head);
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage written at the tail as entries leave the pipeline
    always_ff @(posedge clock) begin
        if (enq) begin
            q_data[tail] <= st_data[LATENCY-1];
            q_eidx[tail] <= st_eidx[LATENCY-1];
            q_gidx[tail] <= st_gidx[LATENCY-1];
            q_tag[tail]  <= st_tag[LATENCY-1];
        end
    end

    // Response bits come from the queue head, or the last stage when bypassing
    always_comb begin
        io_out_bits_data         = '0;
        io_out_bits_executeIndex = '0;
        io_out_bits_groupIndex   = '0;
        io_out_bits_tag          = '0;
        if (!queue_empty) begin
            io_out_bits_data         = q_data[head];
            io_out_bits_executeIndex = q_eidx[head];
            io_out_bits_groupIndex   = q_gidx[head];
            io_out_bits_tag          = q_tag[head];
        end
`ifdef VFU_SLOT_RESPONDER_FLOW_EN
        else if (last_valid) begin
            io_out_bits_data         = st_data[LATENCY-1];
            io_out_bits_executeIndex = st_eidx[LATENCY-1];
            io_out_bits_groupIndex   = st_gidx[LATENCY-1];
            io_out_bits_tag          = st_tag[LATENCY-1];
        end
`endif
    end

endmodule

// File: tb/tb_vfu_slot_responder.sv
// Self-checking bench for vfu_slot_responder (default LATENCY=2, QUEUE_DEPTH=4).
module tb_vfu_slot_responder;

    localparam int LAT = 2;
    localparam int QD  = 4;
`ifdef VFU_SLOT_RESPONDER_FLOW_EN
    localparam int FLOW = 1;
`else
    localparam int FLOW = 0;
`endif
    localparam int EXP_LAT = LAT + 1 - FLOW;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_ready;
    logic        io_in_valid;
    logic [32:0] io_in_bits_src_0;
    logic [32:0] io_in_bits_src_1;
    logic [3:0]  io_in_bits_opcode;
    logic [3:0]  io_in_bits_mask;
    logic [1:0]  io_in_bits_executeIndex;
    logic [5:0]  io_in_bits_groupIndex;
    logic [1:0]  io_in_bits_tag;
    logic        io_out_ready;
    logic        io_out_valid;
    logic [31:0] io_out_bits_data;
    logic [1:0]  io_out_bits_executeIndex;
    logic [5:0]  io_out_bits_groupIndex;
    logic [1:0]  io_out_bits_tag;

    vfu_slot_responder #(.LATENCY(LAT), .QUEUE_DEPTH(QD)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .io_in_ready              (io_in_ready),
        .io_in_valid              (io_in_valid),
        .io_in_bits_src_0         (io_in_bits_src_0),
        .io_in_bits_src_1         (io_in_bits_src_1),
        .io_in_bits_opcode        (io_in_bits_opcode),
        .io_in_bits_mask          (io_in_bits_mask),
        .io_in_bits_executeIndex  (io_in_bits_executeIndex),
        .io_in_bits_groupIndex    (io_in_bits_groupIndex),
        .io_in_bits_tag           (io_in_bits_tag),
        .io_out_ready             (io_out_ready),
        .io_out_valid             (io_out_valid),
        .io_out_bits_data         (io_out_bits_data),
        .io_out_bits_executeIndex (io_out_bits_executeIndex),
        .io_out_bits_groupIndex   (io_out_bits_groupIndex),
        .io_out_bits_tag          (io_out_bits_tag)
    );

    always #5 clock = ~clock;

    // Reference model: every outstanding request in acceptance order, with the
    // cycle from which it is visible on io_out.
    typedef struct {
        logic [31:0] data;
        logic [1:0]  eidx;
        logic [5:0]  gidx;
        logic [1:0]  tag;
        int          vis;
    } resp_t;

    resp_t q[$];
    int    cyc    = 0;
    int    errors = 0;
    int    checks = 0;

    function automatic logic [31:0] ref_exec(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op, input logic [3:0] m);
        logic [31:0] r;
        logic [31:0] keep;
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a ^ b;
            4'd3:    r = a + b;
            default: r = a;
        endcase
        keep = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return r & keep;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_req(input logic v, input logic [32:0] s0, input logic [32:0] s1,
                           input logic [3:0] op, input logic [3:0] m,
                           input logic [1:0] ei, input logic [5:0] gi, input logic [1:0] tg);
        io_in_valid             = v;
        io_in_bits_src_0        = s0;
        io_in_bits_src_1        = s1;
        io_in_bits_opcode       = op;
        io_in_bits_mask         = m;
        io_in_bits_executeIndex = ei;
        io_in_bits_groupIndex   = gi;
        io_in_bits_tag          = tg;
    endtask

    task automatic rand_req(input logic v, input logic [1:0] tg);
        set_req(v, {1'($urandom), 32'($urandom)}, {1'($urandom), 32'($urandom)},
                4'($urandom_range(0, 7)), 4'($urandom), 2'($urandom), 6'($urandom), tg);
    endtask

    // Check outputs against the model, advance the model, then advance one cycle.
    // Called at a falling edge with inputs already driven.
    task automatic tick();
        logic exp_ready;
        logic exp_valid;
        resp_t e;
        #1;
        exp_ready = !reset && (q.size() < QD);
        exp_valid = !reset && (q.size() > 0) && (q[0].vis <= cyc);
        chk("in_ready", 32'(io_in_ready), 32'(exp_ready));
        chk("out_valid", 32'(io_out_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("out_data", io_out_bits_data, q[0].data);
            chk("out_eidx", 32'(io_out_bits_executeIndex), 32'(q[0].eidx));
            chk("out_gidx", 32'(io_out_bits_groupIndex), 32'(q[0].gidx));
            chk("out_tag", 32'(io_out_bits_tag), 32'(q[0].tag));
        end else if (reset) begin
            chk("reset_bits", {io_out_bits_data[21:0], io_out_bits_executeIndex,
                               io_out_bits_groupIndex, io_out_bits_tag}, 32'h0);
            chk("reset_data_hi", 32'(io_out_bits_data[31:22]), 32'h0);
        end
        if (reset) begin
            q.delete();
        end else begin
            if (exp_valid && io_out_ready) void'(q.pop_front());
            if (io_in_valid && exp_ready) begin
                e.data = ref_exec(io_in_bits_src_0[31:0], io_in_bits_src_1[31:0],
                                  io_in_bits_opcode, io_in_bits_mask);
                e.eidx = io_in_bits_executeIndex;
                e.gidx = io_in_bits_groupIndex;
                e.tag  = io_in_bits_tag;
                e.vis  = cyc + EXP_LAT;
                q.push_back(e);
            end
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    // One request on an idle unit; response must appear exactly EXP_LAT cycles later
    task automatic send_and_expect(input string name, input logic [32:0] s0, input logic [32:0] s1,
                                   input logic [3:0] op, input logic [3:0] m,
                                   input logic [1:0] tg, input logic [31:0] expd);
        io_out_ready = 1'b1;
        set_req(1'b1, s0, s1, op, m, 2'd1, 6'd5, tg);
        tick();
        set_req(1'b0, '0, '0, '0, '0, '0, '0, '0);
        repeat (EXP_LAT - 1) tick();
        #1;
        chk({name, "_valid"}, 32'(io_out_valid), 32'h1);
        chk({name, "_data"}, io_out_bits_data, expd);
        chk({name, "_tag"}, 32'(io_out_bits_tag), 32'(tg));
        tick();
    endtask

    task automatic drain();
        io_out_ready = 1'b1;
        set_req(1'b0, '0, '0, '0, '0, '0, '0, '0);
        for (int k = 0; k < 40 && q.size() > 0; k++) tick();
        chk("drain_empty", 32'(q.size()), 32'h0);
        tick();
    endtask

    initial begin
        reset        = 1'b1;
        io_out_ready = 1'b1;
        set_req(1'b0, '0, '0, '0, '0, '0, '0, '0);
        @(negedge clock);
        repeat (3) tick();
        reset = 1'b0;

        // Directed vectors with known results
        send_and_expect("and", 33'h0_0000_00FF, 33'h0_0000_0F0F, 4'd0, 4'hF, 2'd2, 32'h0000_000F);
        send_and_expect("add_wrap", 33'h0_FFFF_FFFF, 33'h1_0000_0001, 4'd3, 4'hF, 2'd1, 32'h0000_0000);
        send_and_expect("add_mask", 33'h1_1234_5678, 33'h0_0000_0000, 4'd3, 4'h5, 2'd3, 32'h0034_0078);

        // Backpressure: queue fills to 4, then drains in tag order
        io_out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rand_req(1'b1, 2'(q.size()));
            tick();
        end
        chk("bp_outstanding", 32'(io_in_ready), 32'h0);
        set_req(1'b0, '0, '0, '0, '0, '0, '0, '0);
        io_out_ready = 1'b1;
        drain();

        // Three outstanding, then accept and pop together
        io_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_req(1'b1, 2'(i));
            tick();
        end
        set_req(1'b0, '0, '0, '0, '0, '0, '0, '0);
        repeat (3) tick();
        io_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_req(1'b1, 2'(i));
            tick();
        end
        drain();

        // Reset with two requests in the pipeline and one queued
        io_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_req(1'b1, 2'(i));
            tick();
        end
        set_req(1'b0, '0, '0, '0, '0, '0, '0, '0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        io_out_ready = 1'b1;
        repeat (6) tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_req(1'($urandom_range(0, 3) != 0), 2'($urandom));
            io_out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
